// File: rtl/moonbase_pkg.sv
// moonbase_pkg: definitions shared by the moonbase bus loader.
//   state_t            - loader control states
//   CODE_WORDS_DEF     - default number of code nibbles per load
//   RELEASE_CYCLES_DEF - default number of cycles cpu_reset is held after a load
//   code_addr()        - maps a 7-bit offset into the code half of the nibble array
package moonbase_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  localparam int unsigned CODE_WORDS_DEF     = 128;
  localparam int unsigned RELEASE_CYCLES_DEF = 2;

  // Code space is the upper half of the 256-entry array.
  function automatic logic [7:0] code_addr(input logic [6:0] offs);
    return {1'b1, offs};
  endfunction

endpackage

// File: rtl/moonbase_nibble_ram.sv
// moonbase_nibble_ram: 256 x 4 storage, one synchronous write port and one
// combinational read port. Contents are not reset.
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write nibble
//   raddr  - read address
//   rdata  - read nibble (combinational)
module moonbase_nibble_ram (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [3:0] wdata,
  input  logic [7:0] raddr,
  output logic [3:0] rdata
);

  logic [3:0] r_mem [256];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/moonbase_bus_loader.sv
// moonbase_bus_loader: program loader and bus bridge for a small nibble CPU.
// A host streams code nibbles into the code half of a 256x4 array while the
// CPU is held in reset; the CPU is then released and uses cpu_bus to access
// the array and to issue device writes.
//   clk        - clock
//   reset      - asynchronous active-high reset
//   cpu_bus    - [7]=address strobe; strobe: [6:0]=address;
//                else {code_sel, ram_we_n, dev_we_n, data[3:0]}
//   load_start - start/restart a program load
//   run_start  - release the CPU without loading (from IDLE only)
//   load_valid, load_data, load_last, load_ready - load nibble handshake
//   cpu_reset  - CPU reset, low only in RUN
//   ram_data   - combinational read data to the CPU
//   dev_addr, dev_wdata, dev_we - device write port
//   busy       - loading or releasing
module moonbase_bus_loader
  import moonbase_pkg::*;
#(
  parameter int unsigned CODE_WORDS     = CODE_WORDS_DEF,
  parameter int unsigned RELEASE_CYCLES = RELEASE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cpu_bus,
  input  logic       load_start,
  input  logic       run_start,
  input  logic       load_valid,
  input  logic [3:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  output logic       cpu_reset,
  output logic [3:0] ram_data,
  output logic [6:0] dev_addr,
  output logic [3:0] dev_wdata,
  output logic       dev_we,
  output logic       busy
);

  localparam logic [7:0] CNT_LAST = 8'(CODE_WORDS - 1);
  localparam logic [7:0] REL_LAST = (RELEASE_CYCLES > 0) ? 8'(RELEASE_CYCLES - 1) : 8'd0;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_rel;
  logic [6:0] r_latch;
  logic       r_cpu_reset;
  logic       r_load_ready;
  logic       r_busy;

  logic       w_run;
  logic       w_cpu_ram_we;
  logic       w_load_xfer;
  logic       w_ram_we;
  logic [7:0] w_ram_waddr;
  logic [3:0] w_ram_wdata;
  logic [7:0] w_ram_raddr;
  logic [3:0] w_ram_rdata;

  assign w_run        = (r_state == ST_RUN);
  assign w_cpu_ram_we = w_run & ~cpu_bus[7] & ~cpu_bus[5];
  // A restart pulse takes priority over a nibble offered in the same cycle.
  assign w_load_xfer  = r_load_ready & load_valid & ~load_start;

  // CPU writes only happen in RUN and loader writes only in LOAD, so the two
  // sources never collide; the loader side of the mux is chosen explicitly.
  assign w_ram_we     = w_cpu_ram_we | w_load_xfer;
  assign w_ram_waddr  = w_load_xfer ? code_addr(r_cnt[6:0]) : {cpu_bus[6], r_latch};
  assign w_ram_wdata  = w_load_xfer ? load_data : cpu_bus[3:0];
  assign w_ram_raddr  = {cpu_bus[6], r_latch};

  moonbase_nibble_ram u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (w_ram_waddr),
    .wdata (w_ram_wdata),
    .raddr (w_ram_raddr),
    .rdata (w_ram_rdata)
  );

  assign ram_data   = cpu_bus[7] ? '0 : w_ram_rdata;
  assign dev_we     = w_run & ~cpu_bus[7] & ~cpu_bus[4];
  assign dev_addr   = r_latch;
  assign dev_wdata  = cpu_bus[3:0];
  assign cpu_reset  = r_cpu_reset;
  assign load_ready = r_load_ready;
  assign busy       = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_rel        <= '0;
      r_latch      <= '0;
      r_cpu_reset  <= 1'b1;
      r_load_ready <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      if (cpu_bus[7]) begin
        r_latch <= cpu_bus[6:0];
      end

      // load_start is honoured from every state, so it is handled ahead of
      // the per-state transitions.
      if (load_start) begin
        r_state      <= ST_LOAD;
        r_cnt        <= '0;
        r_rel        <= '0;
        r_cpu_reset  <= 1'b1;
        r_load_ready <= 1'b1;
        r_busy       <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (run_start) begin
              r_state      <= ST_RELEASE;
              r_rel        <= '0;
              r_cpu_reset  <= 1'b1;
              r_load_ready <= 1'b0;
              r_busy       <= 1'b1;
            end
          end
          ST_LOAD: begin
            if (load_valid) begin
              r_cnt <= r_cnt + 8'd1;
              if (load_last || (r_cnt == CNT_LAST)) begin
                r_state      <= ST_RELEASE;
                r_rel        <= '0;
                r_load_ready <= 1'b0;
              end
            end
          end
          ST_RELEASE: begin
            if (r_rel == REL_LAST) begin
              r_state     <= ST_RUN;
              r_cpu_reset <= 1'b0;
              r_busy      <= 1'b0;
            end else begin
              r_rel <= r_rel + 8'd1;
            end
          end
          ST_RUN: begin
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_moonbase_bus_loader.sv
module tb_moonbase_bus_loader;

  localparam int CW = 128;
  localparam int RC = 2;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_REL  = 2;
  localparam int M_RUN  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cpu_bus;
  logic       load_start, run_start, load_valid, load_last;
  logic [3:0] load_data;
  logic       load_ready, cpu_reset, dev_we, busy;
  logic [3:0] ram_data, dev_wdata;
  logic [6:0] dev_addr;

  moonbase_bus_loader #(.CODE_WORDS(CW), .RELEASE_CYCLES(RC)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_bus    (cpu_bus),
    .load_start (load_start),
    .run_start  (run_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .cpu_reset  (cpu_reset),
    .ram_data   (ram_data),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .dev_we     (dev_we),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_mem [256];   // -1 = never written
  int m_st, m_cnt, m_latch, m_rel, m_old_latch;

  initial for (int i = 0; i < 256; i++) m_mem[i] = -1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st = M_IDLE; m_cnt = 0; m_latch = 0; m_rel = 0;
    end else begin
      m_old_latch = m_latch;
      if (cpu_bus[7]) m_latch = int'(cpu_bus[6:0]);
      if (m_st == M_RUN && !cpu_bus[7] && !cpu_bus[5])
        m_mem[int'(cpu_bus[6]) * 128 + m_old_latch] = int'(cpu_bus[3:0]);
      if (load_start) begin
        m_st = M_LOAD; m_cnt = 0;
      end else if (m_st == M_IDLE) begin
        if (run_start) begin m_st = M_REL; m_rel = 0; end
      end else if (m_st == M_LOAD) begin
        if (load_valid) begin
          m_mem[128 + m_cnt] = int'(load_data);
          m_cnt++;
          if (load_last || m_cnt == CW) begin m_st = M_REL; m_rel = 0; end
        end
      end else if (m_st == M_REL) begin
        m_rel++;
        if (m_rel == RC) m_st = M_RUN;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int exp_dev, exp_rd;
  always @(negedge clk) begin
    chk("cpu_reset", int'(cpu_reset), int'(m_st != M_RUN));
    chk("load_ready", int'(load_ready), int'(m_st == M_LOAD));
    chk("busy", int'(busy), int'(m_st == M_LOAD || m_st == M_REL));
    exp_dev = int'(m_st == M_RUN && !cpu_bus[7] && !cpu_bus[4]);
    chk("dev_we", int'(dev_we), exp_dev);
    chk("dev_addr", int'(dev_addr), m_latch);
    if (exp_dev != 0) chk("dev_wdata", int'(dev_wdata), int'(cpu_bus[3:0]));
    if (cpu_bus[7]) chk("ram_data_strobe", int'(ram_data), 0);
    else begin
      exp_rd = m_mem[int'(cpu_bus[6]) * 128 + m_latch];
      if (exp_rd >= 0) chk("ram_data", int'(ram_data), exp_rd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, output logic [3:0] v);
    cpu_bus = {1'b1, a[6:0]};
    tick();
    cpu_bus = {1'b0, a[7], 2'b11, 4'h0};
    #3;
    v = ram_data;
  endtask

  task automatic wait_run(input string name);
    int n = 0;
    while (cpu_reset && n < 50) begin
      tick();
      n++;
    end
    chk(name, int'(cpu_reset), 0);
  endtask

  task automatic send(input logic [3:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  logic [3:0] v;
  logic [3:0] first_nib;
  int acc, drop_k, n;

  initial begin
    reset = 1'b1;
    cpu_bus = 8'h30; load_start = 0; run_start = 0;
    load_valid = 0; load_data = 0; load_last = 0;
    repeat (3) tick();
    chk("reset_cpu_reset", int'(cpu_reset), 1);
    chk("reset_load_ready", int'(load_ready), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_dev_addr", int'(dev_addr), 0);
    reset = 1'b0;
    tick();

    // Five-nibble load ending on load_last
    load_start = 1; tick(); load_start = 0;
    chk("ready_after_start", int'(load_ready), 1);
    for (int i = 1; i <= 5; i++) send(4'(i), i == 5);
    n = 0;
    while (cpu_reset && n < 20) begin n++; tick(); end
    chk("release_cycles", n, 2);
    chk("busy_after_release", int'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      rd(8'(128 + i), v);
      chk("code_mem_literal", int'(v), i + 1);
      chk("model_code_mem", m_mem[128 + i], i + 1);
    end

    // Address latch, RAM write, same-cycle read
    cpu_bus = 8'h85; tick();
    cpu_bus = 8'h47; #3;
    chk("dev_we_47", int'(dev_we), 1);
    chk("dev_addr_47", int'(dev_addr), 5);
    tick();
    cpu_bus = 8'h70; #3;
    chk("ram_read_back", int'(ram_data), 7);
    tick();

    // Device write without memory write
    cpu_bus = 8'h92; tick();
    cpu_bus = 8'h5B; tick();
    cpu_bus = 8'h6A; #3;
    chk("dev_we_6A", int'(dev_we), 1);
    chk("dev_addr_6A", int'(dev_addr), 8'h12);
    chk("dev_wdata_6A", int'(dev_wdata), 8'hA);
    tick();
    cpu_bus = 8'h70; #3;
    chk("dev_we_one_cycle", int'(dev_we), 0);
    chk("no_mem_write", int'(ram_data), 8'hB);
    tick();
    cpu_bus = 8'h30;

    // Over-long stream: only CODE_WORDS accepted
    load_start = 1; tick(); load_start = 0;
    first_nib = 4'($urandom_range(0, 15));
    acc = 0; drop_k = -1;
    for (int k = 0; k < 130; k++) begin
      load_valid = 1; load_last = 0;
      load_data = (k == 0) ? first_nib : 4'($urandom_range(0, 15));
      #3;
      if (load_ready) acc++;
      else if (drop_k < 0) drop_k = k;
      tick();
    end
    load_valid = 0;
    chk("accepted_count", acc, 128);
    chk("ready_drop_index", drop_k, 128);
    chk("ready_low_after", int'(load_ready), 0);
    wait_run("run_after_stream");
    rd(8'd128, v);
    chk("first_nibble_kept", int'(v), int'(first_nib));

    // Restart from RUN
    load_start = 1; #3;
    chk("cpu_reset_before_restart", int'(cpu_reset), 0);
    tick(); load_start = 0;
    chk("cpu_reset_on_restart", int'(cpu_reset), 1);
    send(4'hC, 1'b1);
    wait_run("run_after_restart");
    rd(8'd128, v);
    chk("restart_lands_128", int'(v), 12);

    // Asynchronous reset mid-load
    load_start = 1; tick(); load_start = 0;
    send(4'h9, 0); send(4'h8, 0); send(4'h7, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_load_ready", int'(load_ready), 0);
    chk("async_cpu_reset", int'(cpu_reset), 1);
    chk("async_busy", int'(busy), 0);
    tick(); reset = 1'b0; tick();
    run_start = 1; tick(); run_start = 0;
    wait_run("run_after_run_start");
    rd(8'd128, v); chk("kept_128", int'(v), 9);
    rd(8'd129, v); chk("kept_129", int'(v), 8);
    rd(8'd130, v); chk("kept_130", int'(v), 7);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      load_start = (r == 0);
      run_start  = (r < 4);
      load_valid = 1'($urandom_range(0, 1));
      load_last  = ($urandom_range(0, 15) == 0);
      load_data  = 4'($urandom_range(0, 15));
      cpu_bus    = 8'($urandom_range(0, 255));
      if (c == 1500) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
      tick();
    end
    load_start = 0; run_start = 0; load_valid = 0; cpu_bus = 8'h30;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
